// File: rtl/bp_be_pkg.sv
// Shared backend types: long-op result widths and the late-writeback
// tracker state encoding.
package bp_be_pkg;

    localparam int long_width_gp = 64;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } rv64_fflags_s;

    typedef enum logic [1:0] {
        e_lwb_idle,
        e_lwb_pending,
        e_lwb_drain,
        e_lwb_wb
    } bp_be_long_wb_state_e;

endpackage

// File: rtl/bsg_dff_reset_en.sv
// Enabled register with asynchronous active-high reset to zero.
module bsg_dff_reset_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            data_o <= '0;
        else if (en_i)
            data_o <= data_i;
    end

endmodule

// File: rtl/bp_be_long_wb_tracker.sv
// Tracks the single in-flight long FP op from issue to late writeback,
// absorbing flushes and exposing hazard/latency info.
module bp_be_long_wb_tracker
    import bp_be_pkg::*;
#(
    parameter int data_width_p     = long_width_gp,
    parameter int fflags_width_p   = $bits(rv64_fflags_s),
    parameter int reg_addr_width_p = 5,
    parameter int lat_width_p      = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,

    input  logic                        issue_v_i,
    input  logic [reg_addr_width_p-1:0] issue_rd_addr_i,
    input  logic                        issue_fp_i,
    output logic                        issue_ready_o,
    input  logic                        flush_i,

    input  logic                        long_v_i,
    input  logic [data_width_p-1:0]     long_data_i,
    input  logic [fflags_width_p-1:0]   long_fflags_i,
    output logic                        long_yumi_o,

    output logic                        busy_o,
    output logic [reg_addr_width_p-1:0] busy_rd_addr_o,
    output logic                        busy_fp_o,

    output logic                        wb_v_o,
    input  logic                        wb_ready_i,
    output logic [reg_addr_width_p-1:0] wb_rd_addr_o,
    output logic                        wb_fp_o,
    output logic [data_width_p-1:0]     wb_data_o,
    output logic [fflags_width_p-1:0]   wb_fflags_o,
    output logic [lat_width_p-1:0]      wb_latency_o
);

    localparam int hold_width_lp =
        data_width_p + fflags_width_p + reg_addr_width_p + 1;

    bp_be_long_wb_state_e state_r;
    logic [lat_width_p-1:0] lat_r;
    logic [lat_width_p-1:0] lat_inc;

    logic                        is_idle, is_pending, is_drain, is_wb;
    logic                        capture_issue, capture_result, hold_en;
    logic [hold_width_lp-1:0]    hold_n, hold_r;
    logic [data_width_p-1:0]     hold_data;
    logic [fflags_width_p-1:0]   hold_fflags;
    logic [reg_addr_width_p-1:0] hold_rd;
    logic                        hold_fp;

    assign is_idle    = (state_r == e_lwb_idle);
    assign is_pending = (state_r == e_lwb_pending);
    assign is_drain   = (state_r == e_lwb_drain);
    assign is_wb      = (state_r == e_lwb_wb);

    assign capture_issue  = is_idle & issue_v_i & ~flush_i;
    assign capture_result = is_pending & long_v_i & ~flush_i;
    assign hold_en        = capture_issue | capture_result;

    // One register holds both halves: rd/fp land at issue, data/fflags at result.
    always_comb begin
        hold_n = {{data_width_p{1'b0}}, {fflags_width_p{1'b0}},
                  issue_rd_addr_i, issue_fp_i};
        if (capture_result)
            hold_n = {long_data_i, long_fflags_i, hold_rd, hold_fp};
    end

    bsg_dff_reset_en #(
        .width_p (hold_width_lp)
    ) hold_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (hold_en),
        .data_i  (hold_n),
        .data_o  (hold_r)
    );

    assign {hold_data, hold_fflags, hold_rd, hold_fp} = hold_r;

    assign lat_inc = (lat_r == '1) ? lat_r : lat_r + lat_width_p'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r <= e_lwb_idle;
            lat_r   <= '0;
        end else begin
            unique case (state_r)
                e_lwb_idle: begin
                    if (issue_v_i) begin
                        state_r <= flush_i ? e_lwb_drain : e_lwb_pending;
                        lat_r   <= '0;
                    end
                end
                e_lwb_pending: begin
                    lat_r <= lat_inc;
                    if (flush_i)
                        state_r <= long_v_i ? e_lwb_idle : e_lwb_drain;
                    else if (long_v_i)
                        state_r <= e_lwb_wb;
                end
                e_lwb_drain: begin
                    if (long_v_i)
                        state_r <= e_lwb_idle;
                end
                e_lwb_wb: begin
                    lat_r <= lat_inc;
                    if (flush_i | wb_ready_i)
                        state_r <= e_lwb_idle;
                end
                default: state_r <= e_lwb_idle;
            endcase
        end
    end

    assign issue_ready_o = is_idle;
    assign long_yumi_o   = long_v_i & (is_pending | is_drain);

    assign busy_o         = is_pending | is_wb;
    assign busy_rd_addr_o = busy_o ? hold_rd : '0;
    assign busy_fp_o      = busy_o & hold_fp;

    // Flush beats grant: a flushed WB cycle never presents a request.
    assign wb_v_o       = is_wb & ~flush_i;
    assign wb_rd_addr_o = wb_v_o ? hold_rd     : '0;
    assign wb_fp_o      = wb_v_o & hold_fp;
    assign wb_data_o    = wb_v_o ? hold_data   : '0;
    assign wb_fflags_o  = wb_v_o ? hold_fflags : '0;
    assign wb_latency_o = wb_v_o ? lat_r       : '0;

    a_issue_only_idle: assert property (
        @(posedge clk_i) disable iff (reset_i) issue_v_i |-> is_idle
    );

endmodule

// File: tb/tb_bp_be_long_wb_tracker.sv
// Self-checking bench for the long-op writeback tracker: table-driven ops
// through a writeback scoreboard plus hand-written flush/reset sequences.
module tb_bp_be_long_wb_tracker;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        issue_v_i;
    logic [4:0]  issue_rd_addr_i;
    logic        issue_fp_i;
    logic        issue_ready_o;
    logic        flush_i;
    logic        long_v_i;
    logic [63:0] long_data_i;
    logic [4:0]  long_fflags_i;
    logic        long_yumi_o;
    logic        busy_o;
    logic [4:0]  busy_rd_addr_o;
    logic        busy_fp_o;
    logic        wb_v_o;
    logic        wb_ready_i;
    logic [4:0]  wb_rd_addr_o;
    logic        wb_fp_o;
    logic [63:0] wb_data_o;
    logic [4:0]  wb_fflags_o;
    logic [7:0]  wb_latency_o;

    always #5 clk_i = ~clk_i;

    bp_be_long_wb_tracker dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .issue_v_i       (issue_v_i),
        .issue_rd_addr_i (issue_rd_addr_i),
        .issue_fp_i      (issue_fp_i),
        .issue_ready_o   (issue_ready_o),
        .flush_i         (flush_i),
        .long_v_i        (long_v_i),
        .long_data_i     (long_data_i),
        .long_fflags_i   (long_fflags_i),
        .long_yumi_o     (long_yumi_o),
        .busy_o          (busy_o),
        .busy_rd_addr_o  (busy_rd_addr_o),
        .busy_fp_o       (busy_fp_o),
        .wb_v_o          (wb_v_o),
        .wb_ready_i      (wb_ready_i),
        .wb_rd_addr_o    (wb_rd_addr_o),
        .wb_fp_o         (wb_fp_o),
        .wb_data_o       (wb_data_o),
        .wb_fflags_o     (wb_fflags_o),
        .wb_latency_o    (wb_latency_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        fp;
        logic [63:0] data;
        logic [4:0]  ff;
        int          wait_c;
        int          stall_c;
        logic [7:0]  want_lat;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic        fp;
        logic [63:0] data;
        logic [4:0]  ff;
        logic [7:0]  lat;
    } wb_exp_t;

    vec_t    vecs[5];
    wb_exp_t sb[$];
    int      n_cmp = 0;
    int      n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard drain: every granted writeback must match the oldest result.
    always @(negedge clk_i) begin
        if (!reset_i && wb_v_o && wb_ready_i) begin
            if (sb.size() == 0) begin
                chk("unexpected_wb", 64'(wb_v_o), 64'd0);
            end else begin
                wb_exp_t e;
                e = sb.pop_front();
                chk("wb_rd", 64'(wb_rd_addr_o), 64'(e.rd));
                chk("wb_fp", 64'(wb_fp_o), 64'(e.fp));
                chk("wb_data", wb_data_o, e.data);
                chk("wb_fflags", 64'(wb_fflags_o), 64'(e.ff));
                chk("wb_latency", 64'(wb_latency_o), 64'(e.lat));
            end
        end
    end

    task automatic run_op(input vec_t v);
        wb_exp_t e;
        issue_v_i       = 1'b1;
        issue_rd_addr_i = v.rd;
        issue_fp_i      = v.fp;
        settle();
        chk("issue_ready", 64'(issue_ready_o), 64'd1);
        tick();
        issue_v_i = 1'b0;
        for (int i = 0; i < v.wait_c; i++) begin
            settle();
            chk("pend_busy", 64'(busy_o), 64'd1);
            chk("pend_rd", 64'(busy_rd_addr_o), 64'(v.rd));
            chk("pend_fp", 64'(busy_fp_o), 64'(v.fp));
            tick();
        end
        long_v_i      = 1'b1;
        long_data_i   = v.data;
        long_fflags_i = v.ff;
        settle();
        chk("pend_yumi", 64'(long_yumi_o), 64'd1);
        e.rd = v.rd; e.fp = v.fp; e.data = v.data; e.ff = v.ff;
        e.lat = v.want_lat;
        sb.push_back(e);
        tick();
        long_v_i    = 1'b0;
        long_data_i = '0;
        wb_ready_i  = 1'b0;
        for (int i = 0; i < v.stall_c; i++) begin
            settle();
            chk("stall_wb_v", 64'(wb_v_o), 64'd1);
            chk("stall_data", wb_data_o, v.data);
            chk("stall_rd", 64'(wb_rd_addr_o), 64'(v.rd));
            chk("stall_busy_rd", 64'(busy_rd_addr_o), 64'(v.rd));
            tick();
        end
        wb_ready_i = 1'b1;
        settle();
        chk("grant_wb_v", 64'(wb_v_o), 64'd1);
        tick();
        wb_ready_i = 1'b0;
        settle();
        chk("post_idle", 64'(issue_ready_o), 64'd1);
        chk("post_busy", 64'(busy_o), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{5'd5,  1'b1, 64'h4000_0000_0000_0000, 5'h01, 12, 0,   8'd13};
        vecs[1] = '{5'd3,  1'b0, 64'hdead_beef_0123_4567, 5'h00, 2,  4,   8'd7};
        vecs[2] = '{5'd31, 1'b0, 64'hffff_ffff_ffff_ffff, 5'h10, 0,  0,   8'd1};
        vecs[3] = '{5'd0,  1'b1, 64'h0000_0000_0000_0001, 5'h1f, 5,  2,   8'd8};
        vecs[4] = '{5'd17, 1'b1, 64'h3ff0_0000_0000_0000, 5'h04, 3,  260, 8'd255};

        reset_i = 1'b1; issue_v_i = 1'b0; issue_rd_addr_i = '0;
        issue_fp_i = 1'b0; flush_i = 1'b0; long_v_i = 1'b1;
        long_data_i = '0; long_fflags_i = '0; wb_ready_i = 1'b0;
        tick();
        chk("rst_ready", 64'(issue_ready_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_yumi", 64'(long_yumi_o), 64'd0);
        chk("rst_wb_v", 64'(wb_v_o), 64'd0);
        chk("rst_latency", 64'(wb_latency_o), 64'd0);
        tick();
        reset_i  = 1'b0;
        long_v_i = 1'b0;
        tick();

        for (int i = 0; i < 5; i++)
            run_op(vecs[i]);

        // Reset mid-PENDING clears immediately and ignores the stale result.
        issue_v_i = 1'b1; issue_rd_addr_i = 5'd7; issue_fp_i = 1'b1;
        tick();
        issue_v_i = 1'b0;
        tick();
        reset_i = 1'b1;
        settle();
        chk("mid_rst_busy", 64'(busy_o), 64'd0);
        chk("mid_rst_ready", 64'(issue_ready_o), 64'd1);
        tick();
        reset_i  = 1'b0;
        long_v_i = 1'b1;
        settle();
        chk("mid_rst_yumi", 64'(long_yumi_o), 64'd0);
        tick();
        long_v_i = 1'b0;
        settle();
        chk("mid_rst_idle", 64'(issue_ready_o), 64'd1);
        tick();

        // Flush two cycles after issue, result ten cycles later.
        wb_ready_i = 1'b1;
        issue_v_i = 1'b1; issue_rd_addr_i = 5'd9; issue_fp_i = 1'b0;
        tick();
        issue_v_i = 1'b0;
        tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            chk("drain_busy", 64'(busy_o), 64'd0);
            chk("drain_ready", 64'(issue_ready_o), 64'd0);
            chk("drain_wb_v", 64'(wb_v_o), 64'd0);
            tick();
        end
        long_v_i = 1'b1;
        settle();
        chk("drain_yumi", 64'(long_yumi_o), 64'd1);
        tick();
        long_v_i = 1'b0;
        settle();
        chk("drain_done", 64'(issue_ready_o), 64'd1);
        chk("drain_no_wb", 64'(wb_v_o), 64'd0);
        wb_ready_i = 1'b0;
        tick();

        // Issue and flush together: next issue refused until yumi.
        issue_v_i = 1'b1; flush_i = 1'b1;
        tick();
        issue_v_i = 1'b0; flush_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("sameflush_ready", 64'(issue_ready_o), 64'd0);
            chk("sameflush_busy", 64'(busy_o), 64'd0);
            tick();
        end
        long_v_i = 1'b1;
        settle();
        chk("sameflush_yumi", 64'(long_yumi_o), 64'd1);
        tick();
        long_v_i = 1'b0;
        settle();
        chk("sameflush_done", 64'(issue_ready_o), 64'd1);
        run_op(vecs[2]);

        // Held 300 cycles in WB saturates latency; flush beats grant.
        issue_v_i = 1'b1; issue_rd_addr_i = 5'd12; issue_fp_i = 1'b1;
        tick();
        issue_v_i = 1'b0; long_v_i = 1'b1; long_data_i = 64'h1234;
        tick();
        long_v_i = 1'b0;
        repeat (300) tick();
        settle();
        chk("sat_latency", 64'(wb_latency_o), 64'd255);
        chk("sat_wb_v", 64'(wb_v_o), 64'd1);
        flush_i = 1'b1; wb_ready_i = 1'b1;
        settle();
        chk("wbflush_wb_v", 64'(wb_v_o), 64'd0);
        chk("wbflush_data", wb_data_o, 64'd0);
        tick();
        flush_i = 1'b0; wb_ready_i = 1'b0;
        settle();
        chk("wbflush_idle", 64'(issue_ready_o), 64'd1);
        chk("wbflush_busy", 64'(busy_o), 64'd0);
        tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bp_be_long_wb_tracker.md
Name: bp_be_long_wb_tracker

Overview:
- Sits directly downstream of the long-latency FP unit (div/sqrt/fcvt long ops).
- Tracks the one in-flight long op: destination reg, fp/int, flush status.
- Consumes the unit's valid/yumi result, holds it, and presents it to the shared late-writeback port with a ready handshake.
- Exposes busy/rd info to the scoreboard for hazard detection; reports per-op latency for perf counters.

Parameters:
data_width_p, 64, result data width (long_width_gp)
fflags_width_p, 5, exception flag width (rv64_fflags_s)
reg_addr_width_p, 5, architectural register address width
lat_width_p, 8, width of saturating issue-to-writeback latency counter

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
issue_v_i  in  1  long op issued this cycle (same strobe drives the FP unit's v_i)
issue_rd_addr_i  in  reg_addr_width_p  destination register of the issued op
issue_fp_i  in  1  1 = FP regfile destination, 0 = int regfile
issue_ready_o  out  1  tracker can accept an issue (state IDLE)
flush_i  in  1  pipeline flush; kills the tracked op
long_v_i  in  1  FP unit result valid
long_data_i  in  data_width_p  FP unit result
long_fflags_i  in  fflags_width_p  FP unit exception flags
long_yumi_o  out  1  result consumed
busy_o  out  1  an op is tracked and not yet written back
busy_rd_addr_o  out  reg_addr_width_p  rd of tracked op (0 when idle)
busy_fp_o  out  1  fp flag of tracked op (0 when idle)
wb_v_o  out  1  writeback request
wb_ready_i  in  1  writeback port grants this cycle
wb_rd_addr_o  out  reg_addr_width_p  writeback rd
wb_fp_o  out  1  writeback targets FP regfile
wb_data_o  out  data_width_p  writeback data
wb_fflags_o  out  fflags_width_p  flags to accumulate into fcsr
wb_latency_o  out  lat_width_p  cycles from issue to wb_v_o

Behaviour:
- Reset is async, active-high: state=IDLE; rd/fp/data/fflags/latency registers = 0. All outputs are 0, except issue_ready_o=1.
- States: IDLE, PENDING, DRAIN, WB.
- IDLE:
  - issue_v_i & ~flush_i → PENDING; capture rd/fp; latency counter = 0.
  - issue_v_i & flush_i → DRAIN (the FP unit has already accepted the op).
  - Otherwise stay in IDLE.
- PENDING:
  - long_yumi_o = long_v_i.
  - long_v_i & ~flush_i → WB; capture data/fflags.
  - flush_i & long_v_i → IDLE; result discarded.
  - flush_i & ~long_v_i → DRAIN.
- DRAIN:
  - long_yumi_o = long_v_i; result discarded; long_v_i → IDLE.
  - flush_i has no further effect.
- WB:
  - wb_v_o = ~flush_i.
  - wb_v_o & wb_ready_i → IDLE.
  - flush_i → IDLE, write cancelled (flush beats grant in the same cycle).
  - Otherwise hold. Data, rd, fp and fflags stay stable while wb_v_o=1 and not granted.
- long_yumi_o is 0 in IDLE and WB. The FP unit's output fifo holds its result until yumi.
- issue_ready_o = (state==IDLE). issue_v_i outside IDLE is a protocol violation; assert in simulation.
- Latency counter: increments each cycle in PENDING and WB; saturates at 2^lat_width_p-1; wb_latency_o = counter value.
- busy_o = state in {PENDING, WB}. DRAIN is not busy: the op is architecturally dead.
- Latency timing: long_v_i in PENDING → wb_v_o asserted the next cycle (1-cycle registered).
- wb_* outputs are zero whenever wb_v_o=0.

Decomposition:
- State enum bp_be_long_wb_state_e (IDLE, PENDING, DRAIN, WB) goes in bp_be_pkg.
- Widths come from existing long_width_gp and rv64_fflags_s.
- Holding register (data+fflags+rd+fp) uses one bsg_dff_reset_en instance. No other sub-module is needed.

Test Plan:
- Reset mid-PENDING (reset_i pulse) → state IDLE immediately, busy_o=0, issue_ready_o=1; a later long_v_i is ignored (yumi=0).
- Issue rd=5 fp=1, long_v_i after 12 cycles with data 0x4000_0000_0000_0000, fflags=0x01, wb_ready_i=1 → wb_v_o next cycle; rd=5, fp=1, data matches, fflags=0x01, wb_latency_o=13; IDLE afterwards.
- Issue rd=3, result arrives, wb_ready_i=0 for 4 cycles → wb_v_o held with stable data; busy_o=1, busy_rd_addr_o=3; grant on cycle 5 → IDLE.
- Issue, flush 2 cycles later, long_v_i 10 cycles later → DRAIN, busy_o=0, long_yumi_o=1 on arrival, no wb_v_o ever; issue_ready_o=1 after.
- Issue and flush same cycle in IDLE → DRAIN; the next issue is refused until the stale result is yumi'd.
- Flush in WB with wb_ready_i=1 same cycle → wb_v_o=0, no write, IDLE next cycle; latency saturates at 255 for an op held 300 cycles.
